// File: rtl/spi_req_sequencer_if.sv
// Wishbone bus between the request sequencer (master) and the spi core slave port.
// The core interrupt travels alongside the bus signals.
interface spi_req_sequencer_if;
    logic [4:0]  m_adr_o;
    logic [31:0] m_dat_o;
    logic [31:0] m_dat_i;
    logic [3:0]  m_sel_o;
    logic        m_we_o;
    logic        m_stb_o;
    logic        m_cyc_o;
    logic        m_ack_i;
    logic        m_int_i;

    modport master (
        output m_adr_o, m_dat_o, m_sel_o, m_we_o, m_stb_o, m_cyc_o,
        input  m_dat_i, m_ack_i, m_int_i
    );

    modport slave (
        input  m_adr_o, m_dat_o, m_sel_o, m_we_o, m_stb_o, m_cyc_o,
        output m_dat_i, m_ack_i, m_int_i
    );
endinterface

// File: rtl/spi_req_sequencer.sv
// Round-robin Wishbone master that runs complete spi core transfers for NREQ requesters.
// Build option SPI_REQ_SEQ_IRQ_EN: wait on the core interrupt instead of polling CTRL.
//
// state   | meaning
// IDLE    | no transfer, arbitrating req_i
// WR_DIV  | writing DIVIDE with the latched divider
// WR_SS   | writing SS, one-hot on the granted requester
// WR_TX   | writing TX_0
// WR_CTRL | writing CTRL with GO and ASS set
// WAIT    | polling CTRL.GO, or waiting for the core interrupt
// RD_RX   | reading RX_0 into rsp_rx_o
// DONE    | one-cycle ack (and error flag) to the granted requester
module spi_req_sequencer #(
    parameter int NREQ     = 4,
    parameter int POLL_MAX = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*32-1:0]   req_tx_i,
    input  logic [NREQ*7-1:0]    req_len_i,
    input  logic [NREQ*3-1:0]    req_mode_i,
    input  logic [15:0]          cfg_div_i,
    output logic [NREQ-1:0]      req_ack_o,
    output logic [31:0]          rsp_rx_o,
    output logic                 rsp_err_o,
    output logic                 busy_o,
    spi_req_sequencer_if.master  bus
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(POLL_MAX + 1);
`ifdef SPI_REQ_SEQ_IRQ_EN
    localparam logic IE_BIT = 1'b1;
`else
    localparam logic IE_BIT = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, WR_DIV, WR_SS, WR_TX, WR_CTRL, WAIT, RD_RX, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] ptr_q, grant_q, pick, off, ptr_nxt;
    logic [GW:0]   sum, wrap;
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [31:0]   tx_q, rx_q;
    logic [6:0]    len_q;
    logic [2:0]    mode_q;
    logic [15:0]   div_q;
    logic          stb_q, stb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          load, capture, acked, bus_state;
    logic [4:0]    acc_adr;
    logic [31:0]   acc_dat, ctrl_word;
    logic [3:0]    acc_sel;
    logic          acc_we;

    logic [31:0] tx_arr   [NREQ];
    logic [6:0]  len_arr  [NREQ];
    logic [2:0]  mode_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign tx_arr[g]   = req_tx_i[g*32 +: 32];
        assign len_arr[g]  = req_len_i[g*7 +: 7];
        assign mode_arr[g] = req_mode_i[g*3 +: 3];
    end

    // Rotate requests so bit 0 is the pointer position, then take the lowest set bit.
    assign req_dbl = {req_i, req_i} >> ptr_q;
    assign req_rot = req_dbl[NREQ-1:0];

    always_comb begin
        off = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req_rot[j]) off = GW'(j);
        end
    end

    assign sum     = {1'b0, ptr_q} + {1'b0, off};
    assign wrap    = sum - (GW+1)'(NREQ);
    assign pick    = (sum >= (GW+1)'(NREQ)) ? wrap[GW-1:0] : sum[GW-1:0];
    assign ptr_nxt = (pick == GW'(NREQ - 1)) ? '0 : pick + GW'(1);

    assign acked     = stb_q & bus.m_ack_i;
    assign ctrl_word = {18'b0, 1'b1, IE_BIT, mode_q, 1'b1, 1'b0, len_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        load    = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    load    = 1'b1;
                    state_d = WR_DIV;
                end
            end
            WR_DIV:  if (acked) state_d = WR_SS;
            WR_SS:   if (acked) state_d = WR_TX;
            WR_TX:   if (acked) state_d = WR_CTRL;
            WR_CTRL: if (acked) state_d = WAIT;
`ifdef SPI_REQ_SEQ_IRQ_EN
            WAIT: begin
                if (bus.m_int_i) begin
                    state_d = RD_RX;
                end else if (cnt_q == CW'(POLL_MAX - 1)) begin
                    cnt_d   = CW'(POLL_MAX);
                    err_d   = 1'b1;
                    state_d = RD_RX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`else
            WAIT: begin
                if (acked) begin
                    if (!bus.m_dat_i[8]) begin
                        state_d = RD_RX;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(POLL_MAX - 1)) begin
                            err_d   = 1'b1;
                            state_d = RD_RX;
                        end
                    end
                end
            end
`endif
            RD_RX: begin
                if (acked) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_adr   = '0;
        acc_dat   = '0;
        acc_sel   = '0;
        acc_we    = 1'b0;
        bus_state = 1'b1;
        case (state_q)
            WR_DIV:  begin acc_adr = 5'h14; acc_sel = 4'b0011; acc_we = 1'b1; acc_dat = {16'b0, div_q}; end
            WR_SS:   begin acc_adr = 5'h18; acc_sel = 4'b0001; acc_we = 1'b1; acc_dat = 32'd1 << grant_q; end
            WR_TX:   begin acc_adr = 5'h00; acc_sel = 4'b1111; acc_we = 1'b1; acc_dat = tx_q; end
            WR_CTRL: begin acc_adr = 5'h10; acc_sel = 4'b0011; acc_we = 1'b1; acc_dat = ctrl_word; end
`ifdef SPI_REQ_SEQ_IRQ_EN
            WAIT:    bus_state = 1'b0;
`else
            WAIT:    begin acc_adr = 5'h10; acc_sel = 4'b1111; end
`endif
            RD_RX:   begin acc_adr = 5'h00; acc_sel = 4'b1111; end
            default: bus_state = 1'b0;
        endcase
    end

    // Strobe drops for one cycle after every ack, so each access starts from a low strobe.
    assign stb_d = bus_state & (stb_q ? ~bus.m_ack_i : 1'b1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stb_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
            grant_q <= '0;
            tx_q    <= '0;
            len_q   <= '0;
            mode_q  <= '0;
            div_q   <= '0;
            rx_q    <= '0;
        end else begin
            stb_q <= stb_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            if (load) begin
                grant_q <= pick;
                ptr_q   <= ptr_nxt;
                tx_q    <= tx_arr[pick];
                len_q   <= len_arr[pick];
                mode_q  <= mode_arr[pick];
                div_q   <= cfg_div_i;
            end
            if (capture) rx_q <= bus.m_dat_i;
        end
    end

`ifndef SPI_REQ_SEQ_IRQ_EN
    logic unused_int;
    assign unused_int = bus.m_int_i;
`endif

    assign bus.m_cyc_o = stb_q;
    assign bus.m_stb_o = stb_q;
    assign bus.m_we_o  = stb_q & acc_we;
    assign bus.m_adr_o = stb_q ? acc_adr : '0;
    assign bus.m_sel_o = stb_q ? acc_sel : '0;
    assign bus.m_dat_o = (stb_q & acc_we) ? acc_dat : '0;

    assign req_ack_o = (state_q == DONE) ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_q) : '0;
    assign rsp_err_o = (state_q == DONE) & err_q;
    assign busy_o    = (state_q != IDLE);
    assign rsp_rx_o  = rx_q;
endmodule

// File: doc/spi_req_sequencer.md
Name: spi_req_sequencer

Overview:
- Wishbone master that shares one spi core among NREQ requesters and runs each transfer end to end.
- Arbitrates requests round-robin, then programs the core in order: DIVIDE, SS, TX_0, CTRL with GO set.
- Waits for the transfer to finish, reads RX_0, and returns the data to the granted requester with a one-cycle ack.
- Sits between client logic and the spi core's Wishbone slave port in the same clk domain.

Parameters:
- NREQ, 4, number of requesters (2..8); requester i drives slave select line i.
- POLL_MAX, 1023, maximum CTRL polls per transfer before an error completion.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_i  in  NREQ  per-requester request level; held high until the matching ack
- req_tx_i  in  NREQ*32  TX data, slice i belongs to requester i
- req_len_i  in  NREQ*7  char_len field, slice i; 0 means 128 bits, core semantics
- req_mode_i  in  NREQ*3  slice i is {lsb, tx_negedge, rx_negedge}
- cfg_div_i  in  16  clock divider value, sampled at grant
- req_ack_o  out  NREQ  one-cycle completion pulse to the granted requester
- rsp_rx_o  out  32  RX data; valid while req_ack_o is nonzero
- rsp_err_o  out  1  high with the ack when a poll timeout occurred
- busy_o  out  1  high from grant until the ack cycle, inclusive
- m_adr_o  out  5  Wishbone address to the core
- m_dat_o  out  32  Wishbone write data
- m_dat_i  in  32  Wishbone read data
- m_sel_o  out  4  byte selects
- m_we_o  out  1  write enable
- m_stb_o  out  1  strobe
- m_cyc_o  out  1  cycle valid
- m_ack_i  in  1  acknowledge from the core
- m_int_i  in  1  core interrupt output

Behaviour:
- Reset values (reset low): all outputs 0, state IDLE, round-robin pointer 0, poll counter 0.
- Reset low mid-transfer drops m_cyc_o and m_stb_o immediately; no ack is issued for the aborted request.
- States: IDLE, WR_DIV, WR_SS, WR_TX, WR_CTRL, WAIT, RD_RX, DONE.
- IDLE, when any req_i bit is high:
  - Grant the first requester at or after the pointer, wrapping modulo NREQ.
  - Latch that requester's tx, len, mode, and cfg_div_i.
  - Set pointer = grant+1, wrapping NREQ-1 to 0.
  - Go to WR_DIV.
- Requests arriving while busy are not lost; they stay pending because req_i is a level.
- Bus access rule: m_cyc_o and m_stb_o rise on state entry and stay high with stable address, data, sel and we until the cycle m_ack_i is sampled high. They deassert the next cycle, which is also the state transition. This gives at least 2 cycles per access; back-to-back strobes never happen, matching the core's ack toggle.
- WR_DIV: adr 0x14, sel 0011, data {16'b0, div}.
- WR_SS: adr 0x18, sel 0001, data = 1<<grant.
- WR_TX: adr 0x00, sel 1111, data = tx.
- WR_CTRL: adr 0x10, sel 0011, data has:
  - bit13 ASS = 1
  - bit12 IE = 0, or 1 when the optional feature is enabled
  - bit11 lsb, bit10 tx_neg, bit9 rx_neg
  - bit8 GO = 1
  - bit7 = 0, bits6:0 = len
- WAIT (polling build): repeat reads of adr 0x10, sel 1111.
  - When the acked read has bit8 = 0, go to RD_RX.
  - Each acked read with bit8 = 1 increments the poll counter.
  - When the counter reaches POLL_MAX, set the error flag and go to RD_RX.
- RD_RX: read adr 0x00; capture m_dat_i on ack into rsp_rx_o.
- DONE: for one cycle, req_ack_o[grant] = 1 and rsp_err_o = error flag; the poll counter and error flag clear. Next state is IDLE, so at least 1 idle cycle separates transfers.
- m_adr_o bits [1:0] are always 0; m_dat_o is 0 during reads.
- rsp_rx_o holds its value after the ack until the next capture.
- Requester dropping req_i mid-transfer: the transfer still completes and the ack is still pulsed.

Optional Feature:
- Macro: SPI_REQ_SEQ_IRQ_EN.
- Defined:
  - WR_CTRL sets IE = 1.
  - WAIT issues no bus cycles; it waits for m_int_i = 1 and then goes to RD_RX.
  - The poll counter counts clk cycles in WAIT instead; timeout is POLL_MAX cycles.
  - The RD_RX ack clears the core's interrupt.
- Undefined: IE = 0 and the polling WAIT described above; m_int_i is ignored.

Test Plan:
- Single transfer: NREQ=4, req_i=0001, tx=0x000000A5, len=8, mode=000, div=2, miso looped to mosi. Expected writes in order:
  - 0x14 = 0x00000002
  - 0x18 = 0x00000001
  - 0x00 = 0x000000A5
  - 0x10 = 0x00002108
  Then req_ack_o = 0001 for exactly 1 cycle, rsp_rx_o = 0x000000A5, rsp_err_o = 0.
- Round-robin: req_i=1111 held, each requester dropping its bit after its ack -> grant order 0,1,2,3; SS writes 0x1, 0x2, 0x4, 0x8.
- Fairness: requesters 1 and 3 request continuously -> grants alternate 1,3,1,3; requesters 0 and 2 are never acked.
- Timeout: POLL_MAX=4, sclk never finishes (the bench stub's CTRL read always returns bit8 = 1). Expected: exactly 4 CTRL polls, one RX read, then the ack with rsp_err_o = 1.
- Reset mid-op: assert reset during WAIT -> m_cyc_o, m_stb_o and busy_o go 0 immediately with no ack. After release, a new req_i=0100 completes normally with SS write 0x4.
- IRQ build with SPI_REQ_SEQ_IRQ_EN defined:
  - CTRL write is 0x00003108.
  - No bus cycles occur between the CTRL write and the m_int_i rise.
  - The RX read follows m_int_i, and m_int_i clears after its ack.
